// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the next-PC sequencer: PC width, sequencer state
// encoding, default vectors/stack depth and the modulo PC increment helper.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    IRQ   = 2'd2
  } pc_seq_state_t;

  localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;
  localparam logic [PC_W-1:0] DEFAULT_IRQ_VECTOR   = 16'h0004;
  localparam int              DEFAULT_RAS_DEPTH    = 4;

  // Word-addressed increment; wraps 16'hFFFF -> 16'h0000 by truncation.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
// Circular return-address stack. A push when full overwrites the oldest entry
// and keeps the count saturated at RAS_DEPTH; a pop when empty changes nothing.
// Both error conditions set sticky flags that only reset clears.
// RAS_DEPTH must be a power of two and at least 2 so the pointer wraps
// naturally.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i         write data_i at the top (wins if pop_i is also high)
//   pop_i          discard the top entry
//   data_i         return address to push
//   data_o         current top entry (valid when !empty_o)
//   empty_o        no live entries
//   full_o         RAS_DEPTH live entries
//   overflow_o     sticky: a push happened while full
//   underflow_o    sticky: a pop happened while empty
// -----------------------------------------------------------------------------
module return_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] data_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;        // next slot to write
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic [PTR_W-1:0] top_idx;

  assign top_idx     = ptr_q - PTR_W'(1);
  assign data_o      = mem_q[top_idx];
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(RAS_DEPTH));
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  // NOTE: the entry array has no reset; count_q alone decides which entries
  // are live, so clearing the storage would only add a reset mux per bit.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (push_i) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (full_o) begin
        overflow_q <= 1'b1;            // oldest entry silently overwritten
      end else begin
        count_q <= count_q + CNT_W'(1);
      end
    end else if (pop_i) begin
      if (empty_o) begin
        underflow_q <= 1'b1;
      end else begin
        ptr_q   <= top_idx;
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Next-PC controller for the 16-bit core. Drives the PC register input
// (NextPc), reads its output back (CurPc), runs the instruction fetch req/ack
// handshake, and resolves branch / jump / call / return / interrupt entry.
//
// Ports:
//   Clk, Reset                  clock, asynchronous active-high reset
//   CurPc                       PC register output
//   NextPc                      value the PC register latches next edge
//   IMemReq / IMemAck           fetch handshake at address CurPc
//   InstrValid                  instruction boundary (ack accepted, no stall)
//   Stall                       pipeline hold
//   BranchTaken, BranchTarget   conditional redirect
//   Jump, JumpTarget            unconditional redirect (also call target)
//   Call, Ret                   push CurPc+1 / pop return address
//   Irq, IrqAck                 level interrupt request, entry pulse
//   RasOverflow, RasUnderflow   sticky return-stack error flags
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [PC_W-1:0] IRQ_VECTOR   = DEFAULT_IRQ_VECTOR,
  parameter int              RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [PC_W-1:0] CurPc,
  output logic [PC_W-1:0] NextPc,
  output logic            IMemReq,
  input  logic            IMemAck,
  output logic            InstrValid,
  input  logic            Stall,
  input  logic            BranchTaken,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            Jump,
  input  logic [PC_W-1:0] JumpTarget,
  input  logic            Call,
  input  logic            Ret,
  input  logic            Irq,
  output logic            IrqAck,
  output logic            RasOverflow,
  output logic            RasUnderflow
);

  pc_seq_state_t   state_q, state_d;
  logic            ras_push, ras_pop;
  logic            ras_empty, ras_full;
  logic [PC_W-1:0] ras_din, ras_top;
  logic [PC_W-1:0] pc_plus1;

  assign pc_plus1 = pc_inc(CurPc);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    NextPc     = CurPc;
    IMemReq    = 1'b0;
    InstrValid = 1'b0;
    IrqAck     = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_din    = pc_plus1;

    case (state_q)
      BOOT: begin
        NextPc  = RESET_VECTOR;
        state_d = FETCH;
      end

      FETCH: begin
        IMemReq    = !Stall;
        // The request is !Stall, so this also drops acks that arrive
        // without a request outstanding.
        InstrValid = IMemAck && !Stall;
        if (InstrValid) begin
          if (Ret) begin
            ras_pop = 1'b1;
            NextPc  = ras_empty ? pc_plus1 : ras_top;
          end else if (Call) begin
            ras_push = 1'b1;
            NextPc   = JumpTarget;
          end else if (Jump) begin
            NextPc = JumpTarget;
          end else if (BranchTaken) begin
            NextPc = BranchTarget;
          end else begin
            NextPc = pc_plus1;
          end
          // The resolved PC is still latched this edge; it becomes the
          // return point pushed in the IRQ cycle.
          if (Irq) begin
            state_d = IRQ;
          end
        end
      end

      IRQ: begin
        ras_push = 1'b1;
        ras_din  = CurPc;
        NextPc   = IRQ_VECTOR;
        IrqAck   = 1'b1;
        state_d  = FETCH;
      end

      default: begin
        NextPc  = RESET_VECTOR;
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  return_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (Clk),
    .rst         (Reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .data_i      (ras_din),
    .data_o      (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full),
    .overflow_o  (RasOverflow),
    .underflow_o (RasUnderflow)
  );

  // A push into a full stack must always leave the overflow flag set.
  a_overflow_sticky : assert property (
    @(posedge Clk) disable iff (Reset) (ras_push && ras_full) |=> RasOverflow
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. The bench owns the PC register
// (CurPc <= NextPc) and the instruction memory side of the handshake.
// Expected values go into a scoreboard queue when stimulus is driven and are
// popped and compared once the DUT has produced the corresponding output.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] CurPc;
  logic [15:0] NextPc;
  logic        IMemReq;
  logic        IMemAck = 1'b0;
  logic        InstrValid;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [15:0] BranchTarget = '0;
  logic        Jump = 1'b0;
  logic [15:0] JumpTarget = '0;
  logic        Call = 1'b0;
  logic        Ret = 1'b0;
  logic        Irq = 1'b0;
  logic        IrqAck;
  logic        RasOverflow;
  logic        RasUnderflow;

  int n_vec = 0;
  int n_err = 0;

  string       sb_tag[$];
  logic [31:0] sb_val[$];

  always #5 Clk = ~Clk;

  // PC register outside the sequencer.
  always @(posedge Clk) CurPc <= NextPc;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .CurPc        (CurPc),
    .NextPc       (NextPc),
    .IMemReq      (IMemReq),
    .IMemAck      (IMemAck),
    .InstrValid   (InstrValid),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Call         (Call),
    .Ret          (Ret),
    .Irq          (Irq),
    .IrqAck       (IrqAck),
    .RasOverflow  (RasOverflow),
    .RasUnderflow (RasUnderflow)
  );

  task automatic sb_push(input string t, input logic [31:0] v);
    sb_tag.push_back(t);
    sb_val.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_vec++;
    if (sb_val.size() == 0) begin
      n_err++;
      $error("FAIL sb_underrun: observed %h with no expectation queued", obs);
    end else begin
      t = sb_tag.pop_front();
      e = sb_val.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] e);
    sb_push(t, e);
    sb_check(obs);
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // One accepted instruction with zero-wait ack; checks the PC after the edge.
  task automatic exec(input string tag, input logic r, input logic c,
                      input logic j, input logic [15:0] jt,
                      input logic b, input logic [15:0] bt,
                      input logic irq, input logic [15:0] exp_pc);
    Ret = r; Call = c; Jump = j; JumpTarget = jt;
    BranchTaken = b; BranchTarget = bt; Irq = irq;
    Stall = 1'b0; IMemAck = 1'b1;
    #1;
    chk({tag, "_valid"}, InstrValid, 1);
    sb_push(tag, exp_pc);
    tick();
    Ret = 0; Call = 0; Jump = 0; BranchTaken = 0; Irq = 0; IMemAck = 0;
    #1;
    sb_check(CurPc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    #1 Reset = 1'b1;
    @(negedge Clk); #1;
    chk("rst_nextpc", NextPc, 16'h0000);
    chk("rst_req",    IMemReq, 0);
    chk("rst_valid",  InstrValid, 0);
    chk("rst_irqack", IrqAck, 0);
    chk("rst_ovf",    RasOverflow, 0);
    chk("rst_unf",    RasUnderflow, 0);
    tick();
    Reset = 1'b0;
    tick(); #1;
    chk("boot_pc",  CurPc, 16'h0000);
    chk("boot_req", IMemReq, 1);

    // ---------------- reset mid-handshake at 0x0123 ----------------
    exec("jmp_0123", 0, 0, 1, 16'h0123, 0, 16'h0, 0, 16'h0123);
    IMemAck = 1'b1;
    #1 Reset = 1'b1;
    #1;
    chk("midrst_nextpc", NextPc, 16'h0000);
    chk("midrst_req",    IMemReq, 0);
    chk("midrst_valid",  InstrValid, 0);
    IMemAck = 1'b0;
    tick();
    Reset = 1'b0;
    tick(); #1;
    chk("rerst_pc",  CurPc, 16'h0000);
    chk("rerst_req", IMemReq, 1);

    // ---------------- sequential wrap ----------------
    exec("jmp_fffe", 0, 0, 1, 16'hFFFE, 0, 16'h0, 0, 16'hFFFE);
    exec("seq_ffff", 0, 0, 0, 16'h0,    0, 16'h0, 0, 16'hFFFF);
    exec("seq_0000", 0, 0, 0, 16'h0,    0, 16'h0, 0, 16'h0000);

    // ---------------- 3-cycle wait, redirects ignored ----------------
    for (int i = 0; i < 3; i++) begin
      Jump = 1'b1; JumpTarget = 16'h0BAD;
      #1;
      chk("wait_req",    IMemReq, 1);
      chk("wait_valid",  InstrValid, 0);
      chk("wait_nextpc", NextPc, 16'h0000);
      tick(); #1;
      chk("wait_curpc",  CurPc, 16'h0000);
    end
    Jump = 1'b0;
    exec("after_wait", 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0001);

    // ---------------- call / ret ----------------
    exec("jmp_0010", 0, 0, 1, 16'h0010, 0, 16'h0, 0, 16'h0010);
    exec("call_0200", 0, 1, 0, 16'h0200, 0, 16'h0, 0, 16'h0200);
    exec("seq_0201",  0, 0, 0, 16'h0,    0, 16'h0, 0, 16'h0201);
    exec("ret_0011",  1, 0, 0, 16'h0,    0, 16'h0, 0, 16'h0011);

    // ---------------- RAS overflow / underflow ----------------
    exec("jmp_0100", 0, 0, 1, 16'h0100, 0, 16'h0, 0, 16'h0100);
    exec("call1", 0, 1, 0, 16'h1000, 0, 16'h0, 0, 16'h1000);
    exec("call2", 0, 1, 0, 16'h2000, 0, 16'h0, 0, 16'h2000);
    exec("call3", 0, 1, 0, 16'h3000, 0, 16'h0, 0, 16'h3000);
    exec("call4", 0, 1, 0, 16'h4000, 0, 16'h0, 0, 16'h4000);
    chk("ovf_at_full", RasOverflow, 0);
    exec("call5", 0, 1, 0, 16'h5000, 0, 16'h0, 0, 16'h5000);
    chk("ovf_set", RasOverflow, 1);
    exec("ret1", 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h4001);
    exec("ret2", 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h3001);
    exec("ret3", 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h2001);
    exec("ret4", 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h1001);
    chk("unf_clear", RasUnderflow, 0);
    exec("ret5_empty", 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h1002);
    chk("unf_set",   RasUnderflow, 1);
    chk("ovf_stick", RasOverflow, 1);

    // ---------------- Call+Ret: Ret wins, no push ----------------
    exec("call_0300",   0, 1, 0, 16'h0300, 0, 16'h0, 0, 16'h0300);
    exec("callret",     1, 1, 0, 16'h0500, 0, 16'h0, 0, 16'h1003);
    exec("ret_nopush",  1, 0, 0, 16'h0,    0, 16'h0, 0, 16'h1004);

    // ---------------- interrupt over a taken branch ----------------
    exec("jmp_0040", 0, 0, 1, 16'h0040, 0, 16'h0, 0, 16'h0040);
    exec("br_irq",   0, 0, 0, 16'h0, 1, 16'h0080, 1, 16'h0080);
    chk("irq_ack",    IrqAck, 1);
    chk("irq_req",    IMemReq, 0);
    chk("irq_nextpc", NextPc, 16'h0004);
    Irq = 1'b1;
    tick(); #1;
    chk("irq_vec",     CurPc, 16'h0004);
    chk("irq_ackdrop", IrqAck, 0);
    tick(); #1;
    chk("irq_noresample", IrqAck, 0);
    Irq = 1'b0;
    exec("irq_ret", 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0080);

    // ---------------- interrupt with a call: call push then IRQ push --------
    exec("call_irq", 0, 1, 0, 16'h0600, 0, 16'h0, 1, 16'h0600);
    chk("callirq_ack", IrqAck, 1);
    tick(); #1;
    chk("callirq_vec", CurPc, 16'h0004);
    exec("callirq_ret1", 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0600);
    exec("callirq_ret2", 1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0081);

    // ---------------- stall, then Jump vs Branch priority ----------------
    Stall = 1'b1; IMemAck = 1'b1; Jump = 1'b1; JumpTarget = 16'h0700;
    #1;
    chk("stall_req",    IMemReq, 0);
    chk("stall_valid",  InstrValid, 0);
    chk("stall_nextpc", NextPc, 16'h0081);
    tick(); #1;
    chk("stall_hold", CurPc, 16'h0081);
    Stall = 1'b0; IMemAck = 1'b0; Jump = 1'b0;
    exec("jmp_over_br", 0, 0, 1, 16'h0900, 1, 16'h0A00, 0, 16'h0900);

    chk("sb_drained", sb_val.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
